// File: rtl/key_spi_tx_if.sv
// Keypad-to-SPI transmitter bus: capture/start strobes from the keypad FSM and
// the SPI mode-0 output pins plus status pulses.
interface key_spi_tx_if #(
  parameter int DATA_W = 8
);
  logic              latch_en;
  logic              data_ready;
  logic [DATA_W-1:0] din;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              done;
  logic              overrun;

  // Strobes are single-cycle requests with no ready back-pressure: a
  // data_ready seen while busy is dropped and reported on overrun instead.
  modport master (
    output latch_en, data_ready, din,
    input  sclk, mosi, cs_n, busy, done, overrun
  );

  modport slave (
    input  latch_en, data_ready, din,
    output sclk, mosi, cs_n, busy, done, overrun
  );
endinterface

// File: rtl/key_spi_tx.sv
// Serialises a latched key code over SPI mode 0, MSB first, with every output
// registered and a one-cycle done pulse at the end of each transfer.
module key_spi_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  key_spi_tx_if.slave bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    SHIFT_HI = 2'd2,
    SHIFT_LO = 2'd3
  } state_t;

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] hold, hold_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              sclk_q, sclk_nxt;
  logic              mosi_q, mosi_nxt;
  logic              cs_n_q, cs_n_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              overrun_q, overrun_nxt;
  logic              div_last;
  logic              bit_last;

  assign div_last = (div_cnt == CNT_W'(CLK_DIV - 1));
  // bit_cnt counts sclk rises, so it reaches DATA_W during the last bit.
  assign bit_last = (bit_cnt == BIT_W'(DATA_W));

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    hold_nxt    = hold;
    shreg_nxt   = shreg;
    sclk_nxt    = 1'b0;
    mosi_nxt    = mosi_q;
    cs_n_nxt    = cs_n_q;
    done_nxt    = 1'b0;
    overrun_nxt = 1'b0;

    if (state != IDLE) begin
      div_cnt_nxt = div_last ? '0 : div_cnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (bus.latch_en) hold_nxt = bus.din;
        if (bus.data_ready) begin
          state_nxt   = SETUP;
          cs_n_nxt    = 1'b0;
          // A same-cycle latch bypasses the hold register.
          shreg_nxt   = bus.latch_en ? bus.din : hold;
          mosi_nxt    = shreg_nxt[DATA_W-1];
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
      end
      SETUP: begin
        if (div_last) begin
          state_nxt   = SHIFT_HI;
          sclk_nxt    = 1'b1;
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        sclk_nxt = 1'b1;
        if (div_last) begin
          state_nxt = SHIFT_LO;
          sclk_nxt  = 1'b0;
          if (!bit_last) begin
            shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
            mosi_nxt  = shreg[DATA_W-2];
          end
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          if (bit_last) begin
            state_nxt   = IDLE;
            cs_n_nxt    = 1'b1;
            mosi_nxt    = 1'b0;
            done_nxt    = 1'b1;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt   = SHIFT_HI;
            sclk_nxt    = 1'b1;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
    endcase

    if (state != IDLE && bus.data_ready) overrun_nxt = 1'b1;
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      shreg     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      hold      <= hold_nxt;
      shreg     <= shreg_nxt;
      sclk_q    <= sclk_nxt;
      mosi_q    <= mosi_nxt;
      cs_n_q    <= cs_n_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_key_spi_tx.sv
// Directed bench for key_spi_tx: a word-level scoreboard on the default
// instance plus a short run on a CLK_DIV=1 instance.
module tb_key_spi_tx;
  localparam int W    = 8;
  localparam int LOW0 = 4 * (2 * W + 1);
  localparam int LOW1 = 1 * (2 * W + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg0, state_dbg1;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_word = '0;
  logic [W-1:0] exp_word;
  int  rx_cnt   = 0;
  int  low_cnt  = 0;
  int  high_cnt = 0;
  int  last_gap = 0;
  int  done_cnt = 0;
  int  ovr_cnt  = 0;
  logic prev_sclk = 1'b0;
  logic hi_bit    = 1'b0;

  key_spi_tx_if #(.DATA_W(W)) b0();
  key_spi_tx_if #(.DATA_W(W)) b1();

  key_spi_tx #(.DATA_W(W), .CLK_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .state_dbg(state_dbg0)
  );
  key_spi_tx #(.DATA_W(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .state_dbg(state_dbg1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor for the default instance: assembles each frame and scores it at cs_n rise.
  always @(negedge clk) begin
    if (rst) begin
      rx_cnt    = 0;
      low_cnt   = 0;
      high_cnt  = 0;
      prev_sclk = 1'b0;
    end else begin
      if (b0.overrun) ovr_cnt++;
      if (b0.done) begin
        done_cnt++;
        check("done_outputs", {b0.cs_n, b0.sclk, b0.mosi, b0.busy}, 4'b1000);
      end
      if (b0.sclk && !prev_sclk) begin
        rx_word = {rx_word[W-2:0], b0.mosi};
        rx_cnt++;
        hi_bit = b0.mosi;
      end else if (b0.sclk) begin
        check("mosi_stable_hi", b0.mosi, hi_bit);
      end
      if (!b0.cs_n) begin
        if (low_cnt == 0) last_gap = high_cnt;
        low_cnt++;
        high_cnt = 0;
      end else begin
        if (low_cnt != 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            exp_word = exp_q.pop_front();
            check("frame_word", rx_word, exp_word);
            check("sclk_rises", rx_cnt, W);
            check("cs_low_len", low_cnt, LOW0);
          end
        end
        rx_cnt  = 0;
        low_cnt = 0;
        high_cnt++;
      end
      prev_sclk = b0.sclk;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!b0.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", b0.done, 1'b1);
  endtask

  task automatic send(input logic [W-1:0] val, input bit same_cycle);
    b0.din = val;
    b0.latch_en = 1'b1;
    if (!same_cycle) begin
      @(negedge clk);
      b0.latch_en = 1'b0;
      b0.din = '0;
      idle(2);
    end
    b0.data_ready = 1'b1;
    exp_q.push_back(val);
    @(negedge clk);
    b0.data_ready = 1'b0;
    b0.latch_en = 1'b0;
  endtask

  initial begin
    int done_snap, ovr_snap, rises, n, fast_low, fast_rises, fast_done, bad_period, last_rise;
    logic p_sclk;
    logic [W-1:0] fast_word;

    rst = 1'b1;
    b0.latch_en = 1'b0; b0.data_ready = 1'b0; b0.din = '0;
    b1.latch_en = 1'b0; b1.data_ready = 1'b0; b1.din = '0;
    #2;
    check("reset_outputs", {b0.cs_n, b0.sclk, b0.mosi, b0.busy, b0.done, b0.overrun}, 6'b100000);
    check("reset_state", state_dbg0, 2'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // A5 with latch two cycles ahead of the start strobe
    send(8'hA5, 1'b0);
    check("start_outputs", {b0.busy, b0.cs_n, b0.mosi, b0.sclk}, 4'b1010);
    wait_done();
    idle(4);

    // same-cycle latch and start transmits the live din
    send(8'h3C, 1'b1);
    wait_done();
    idle(4);

    // start and latch during a transfer: overrun, frame and hold untouched
    send(8'hA5, 1'b0);
    idle(20);
    ovr_snap = ovr_cnt;
    b0.din = 8'hFF; b0.latch_en = 1'b1; b0.data_ready = 1'b1;
    @(negedge clk);
    b0.din = '0; b0.latch_en = 1'b0; b0.data_ready = 1'b0;
    idle(2);
    check("overrun_pulse", ovr_cnt - ovr_snap, 1);
    wait_done();
    idle(4);
    b0.data_ready = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    b0.data_ready = 1'b0;
    wait_done();
    idle(4);

    // start accepted in the done cycle; one-cycle cs_n gap
    send(8'hC3, 1'b0);
    wait_done();
    b0.din = 8'h5A; b0.latch_en = 1'b1; b0.data_ready = 1'b1;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    b0.din = '0; b0.latch_en = 1'b0; b0.data_ready = 1'b0;
    wait_done();
    check("cs_gap", last_gap, 1);
    idle(4);

    // asynchronous reset after the third sclk rise
    done_snap = done_cnt;
    send(8'hA5, 1'b0);
    rises = 0; n = 0; p_sclk = 1'b0;
    while (rises < 3 && n < 200) begin
      @(negedge clk);
      if (b0.sclk && !p_sclk) rises++;
      p_sclk = b0.sclk;
      n++;
    end
    check("third_rise_seen", rises, 3);
    check("sclk_high_before_rst", b0.sclk, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {b0.cs_n, b0.sclk, b0.mosi, b0.busy}, 4'b1000);
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    idle(10);
    check("no_done_on_abort", done_cnt, done_snap);

    // hold cleared by reset, then a clean 81 frame
    b0.data_ready = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk);
    b0.data_ready = 1'b0;
    wait_done();
    idle(4);
    send(8'h81, 1'b0);
    wait_done();
    idle(6);

    // CLK_DIV=1 instance
    b1.din = 8'h96; b1.latch_en = 1'b1; b1.data_ready = 1'b1;
    fast_low = 0; fast_rises = 0; fast_done = 0; bad_period = 0; last_rise = -1;
    fast_word = '0; p_sclk = 1'b0; n = 0;
    while (n < 100) begin
      @(negedge clk);
      b1.latch_en = 1'b0; b1.data_ready = 1'b0; b1.din = '0;
      if (b1.done) fast_done++;
      if (!b1.cs_n) fast_low++;
      if (b1.sclk && !p_sclk) begin
        fast_word = {fast_word[W-2:0], b1.mosi};
        if (last_rise >= 0 && n - last_rise != 2) bad_period++;
        last_rise = n;
        fast_rises++;
      end
      p_sclk = b1.sclk;
      if (fast_low > 0 && b1.cs_n) break;
      n++;
    end
    idle(3);
    check("fast_word", fast_word, 8'h96);
    check("fast_rises", fast_rises, W);
    check("fast_period", bad_period, 0);
    check("fast_cs_low_len", fast_low, LOW1);
    check("fast_done", fast_done, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    check("total_done", done_cnt, 8);
    check("total_overrun", ovr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
